// File: rtl/brush_stamper.sv
// brush_stamper: turns one laser hit into a raster of single-pixel writes
// covering a (2r+1)x(2r+1) square brush, and runs a full-screen clear sweep.
// Output coordinates are doubled; the framebuffer consumes bits [10:1].
module brush_stamper #(
    parameter int MAX_X = 799,
    parameter int MAX_Y = 524
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [10:0] laser_x,
    input  logic [10:0] laser_y,
    input  logic        laser_valid,
    input  logic [1:0]  color_In,
    input  logic [1:0]  brush_size,
    input  logic        clear_req,
    output logic [10:0] x_draw,
    output logic [10:0] y_draw,
    output logic [1:0]  data_In,
    output logic        drawDot,
    output logic        busy,
    output logic        clear_done
);

    localparam int XW = $clog2(MAX_X + 1);
    localparam int YW = $clog2(MAX_Y + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAMP = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [9:0]          cx_r, cy_r;
    logic [1:0]          col_r, rad_r;
    logic signed [2:0]   dx_r, dy_r;
    logic [XW-1:0]       clr_x_r;
    logic [YW-1:0]       clr_y_r;
    logic                pend_r;
    logic                clr_fin_r;
    logic                rec_valid_r;
    logic [9:0]          rec_cx_r, rec_cy_r;
    logic [1:0]          rec_col_r, rec_rad_r;

    logic signed [2:0]   rad_s;
    logic signed [11:0]  px_s, py_s;
    logic                in_bounds_s, stamp_last_s, clr_last_s, dup_s, accept_s;
    logic [10:0]         draw_x_s, draw_y_s;
    logic [1:0]          data_s;
    logic                dot_s, busy_s;

    assign rad_s        = $signed({1'b0, rad_r});
    assign px_s         = $signed({2'b00, cx_r}) + $signed({{9{dx_r[2]}}, dx_r});
    assign py_s         = $signed({2'b00, cy_r}) + $signed({{9{dy_r[2]}}, dy_r});
    assign in_bounds_s  = (px_s[11] == 1'b0) && (px_s <= 12'(MAX_X)) &&
                          (py_s[11] == 1'b0) && (py_s <= 12'(MAX_Y));
    assign stamp_last_s = (dx_r == rad_s) && (dy_r == rad_s);
    assign clr_last_s   = (clr_x_r == XW'(MAX_X)) && (clr_y_r == YW'(MAX_Y));
    // A hit identical to the last completed stamp would redraw the same pixels.
    assign dup_s        = rec_valid_r && (rec_cx_r == laser_x[10:1]) &&
                          (rec_cy_r == laser_y[10:1]) && (rec_col_r == color_In) &&
                          (rec_rad_r == brush_size);
    assign accept_s     = (state_r == IDLE) && !clear_req && laser_valid && !dup_s;

    // State register
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a clear always beats a simultaneous hit
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (clear_req) begin
                    state_s = CLEAR;
                end else if (laser_valid && !dup_s) begin
                    state_s = STAMP;
                end else begin
                    state_s = IDLE;
                end
            end
            STAMP: begin
                if (stamp_last_s) begin
                    if (pend_r || clear_req) begin
                        state_s = CLEAR;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STAMP;
                end
            end
            CLEAR: begin
                if (clr_last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLEAR;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode: pixel for the current offset/sweep position
    always_comb begin
        draw_x_s = x_draw;
        draw_y_s = y_draw;
        data_s   = data_In;
        dot_s    = 1'b0;
        busy_s   = 1'b0;
        case (state_r)
            STAMP: begin
                draw_x_s = {px_s[9:0], 1'b0};
                draw_y_s = {py_s[9:0], 1'b0};
                data_s   = col_r;
                dot_s    = in_bounds_s;
                busy_s   = 1'b1;
            end
            CLEAR: begin
                draw_x_s = {10'(clr_x_r), 1'b0};
                draw_y_s = {10'(clr_y_r), 1'b0};
                data_s   = 2'd0;
                dot_s    = 1'b1;
                busy_s   = 1'b1;
            end
            IDLE:    dot_s = 1'b0;
            default: dot_s = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge Clk) begin
        if (reset) begin
            x_draw     <= 11'd0;
            y_draw     <= 11'd0;
            data_In    <= 2'd0;
            drawDot    <= 1'b0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            x_draw     <= draw_x_s;
            y_draw     <= draw_y_s;
            data_In    <= data_s;
            drawDot    <= dot_s;
            busy       <= busy_s;
            clear_done <= clr_fin_r;
        end
    end

    // Datapath: hit latch, brush offsets, sweep counters, pending clear, last-stamp record
    always_ff @(posedge Clk) begin
        if (reset) begin
            cx_r        <= 10'd0;
            cy_r        <= 10'd0;
            col_r       <= 2'd0;
            rad_r       <= 2'd0;
            dx_r        <= 3'sd0;
            dy_r        <= 3'sd0;
            clr_x_r     <= {XW{1'b0}};
            clr_y_r     <= {YW{1'b0}};
            pend_r      <= 1'b0;
            clr_fin_r   <= 1'b0;
            rec_valid_r <= 1'b0;
            rec_cx_r    <= 10'd0;
            rec_cy_r    <= 10'd0;
            rec_col_r   <= 2'd0;
            rec_rad_r   <= 2'd0;
        end else begin
            clr_fin_r <= (state_r == CLEAR) && clr_last_s;
            case (state_r)
                IDLE: begin
                    clr_x_r <= {XW{1'b0}};
                    clr_y_r <= {YW{1'b0}};
                    pend_r  <= 1'b0;
                    if (accept_s) begin
                        cx_r  <= laser_x[10:1];
                        cy_r  <= laser_y[10:1];
                        col_r <= color_In;
                        rad_r <= brush_size;
                        dx_r  <= 3'sd0 - $signed({1'b0, brush_size});
                        dy_r  <= 3'sd0 - $signed({1'b0, brush_size});
                    end
                end
                STAMP: begin
                    clr_x_r <= {XW{1'b0}};
                    clr_y_r <= {YW{1'b0}};
                    if (stamp_last_s) begin
                        pend_r      <= 1'b0;
                        rec_valid_r <= 1'b1;
                        rec_cx_r    <= cx_r;
                        rec_cy_r    <= cy_r;
                        rec_col_r   <= col_r;
                        rec_rad_r   <= rad_r;
                    end else begin
                        if (clear_req) begin
                            pend_r <= 1'b1;
                        end
                        if (dx_r == rad_s) begin
                            dx_r <= -rad_s;
                            dy_r <= dy_r + 3'sd1;
                        end else begin
                            dx_r <= dx_r + 3'sd1;
                        end
                    end
                end
                CLEAR: begin
                    pend_r <= 1'b0;
                    if (clr_last_s) begin
                        clr_x_r     <= {XW{1'b0}};
                        clr_y_r     <= {YW{1'b0}};
                        rec_valid_r <= 1'b0;
                    end else if (clr_x_r == XW'(MAX_X)) begin
                        clr_x_r <= {XW{1'b0}};
                        clr_y_r <= clr_y_r + YW'(1);
                    end else begin
                        clr_x_r <= clr_x_r + XW'(1);
                    end
                end
                default: pend_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_brush_stamper.sv
// Testbench for brush_stamper: a reference model pushes expected pixels to a
// queue, and every drawDot pops and compares. Smaller framebuffer size keeps
// the clear sweep short.
module tb_brush_stamper;

    localparam int BMAX_X = 159;
    localparam int BMAX_Y = 119;
    localparam int NPIX   = (BMAX_X + 1) * (BMAX_Y + 1);

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] laser_x = 11'd0, laser_y = 11'd0;
    logic        laser_valid = 1'b0;
    logic [1:0]  color_In = 2'd0, brush_size = 2'd0;
    logic        clear_req = 1'b0;
    logic [10:0] x_draw, y_draw;
    logic [1:0]  data_In;
    logic        drawDot, busy, clear_done;

    brush_stamper #(.MAX_X(BMAX_X), .MAX_Y(BMAX_Y)) dut (
        .Clk(Clk), .reset(reset), .laser_x(laser_x), .laser_y(laser_y),
        .laser_valid(laser_valid), .color_In(color_In), .brush_size(brush_size),
        .clear_req(clear_req), .x_draw(x_draw), .y_draw(y_draw), .data_In(data_In),
        .drawDot(drawDot), .busy(busy), .clear_done(clear_done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  d;
    } pix_t;

    typedef struct {
        int lx, ly, col, r, exp_busy, exp_dots;
    } vec_t;

    pix_t exp_q[$];
    vec_t vecs[9];

    int checks = 0, errors = 0;
    int cyc = 0;
    int busy_cnt, dot_cnt, first_busy, last_busy, done_cnt, done_cyc;
    logic done_busy;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_window();
        busy_cnt = 0; dot_cnt = 0; first_busy = -1; last_busy = -1;
        done_cnt = 0; done_cyc = -1; done_busy = 1'b0;
    endtask

    // One clock: sample outputs at the falling edge, score each pixel write
    task automatic tick();
        pix_t p;
        @(negedge Clk);
        cyc++;
        if (busy) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = cyc;
            last_busy = cyc;
        end
        if (clear_done) begin
            done_cnt++; done_cyc = cyc; done_busy = busy;
        end
        if (drawDot) begin
            dot_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dot: got (%0d,%0d,%0d) expected no write", x_draw, y_draw, data_In);
            end else begin
                p = exp_q.pop_front();
                if ({x_draw, y_draw, data_In} !== p) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                             x_draw, y_draw, data_In, p.x, p.y, p.d);
                end
            end
        end
    endtask

    // Reference brush: raster over offsets, keep only in-bounds pixels
    task automatic push_stamp(input int lx, input int ly, input int col, input int r, input int limit);
        int cx, cy, px, py, n;
        pix_t p;
        cx = lx / 2; cy = ly / 2; n = 0;
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                px = cx + dx; py = cy + dy;
                if (n < limit && px >= 0 && px <= BMAX_X && py >= 0 && py <= BMAX_Y) begin
                    p.x = 11'(px * 2); p.y = 11'(py * 2); p.d = 2'(col);
                    exp_q.push_back(p);
                end
                n++;
            end
        end
    endtask

    task automatic push_clear();
        pix_t p;
        for (int y = 0; y <= BMAX_Y; y++) begin
            for (int x = 0; x <= BMAX_X; x++) begin
                p.x = 11'(x * 2); p.y = 11'(y * 2); p.d = 2'd0;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic drive_hit(input int lx, input int ly, input int col, input int r);
        laser_x = 11'(lx); laser_y = 11'(ly); color_In = 2'(col); brush_size = 2'(r);
        laser_valid = 1'b1;
    endtask

    initial begin
        int a0, n;
        vecs[0] = '{200, 100, 2, 1, 9, 9};
        vecs[1] = '{200, 100, 2, 1, 0, 0};
        vecs[2] = '{200, 100, 3, 1, 9, 9};
        vecs[3] = '{0, 0, 1, 1, 9, 4};
        vecs[4] = '{318, 238, 1, 1, 9, 4};
        vecs[5] = '{100, 60, 2, 0, 1, 1};
        vecs[6] = '{300, 200, 3, 3, 49, 49};
        vecs[7] = '{2, 2, 1, 2, 25, 16};
        vecs[8] = '{201, 101, 2, 1, 9, 9};

        start_window();
        repeat (3) tick();
        check("rst_x_draw", int'(x_draw), 0);
        check("rst_y_draw", int'(y_draw), 0);
        check("rst_data_In", int'(data_In), 0);
        check("rst_drawDot", int'(drawDot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_clear_done", int'(clear_done), 0);
        reset = 1'b0;
        repeat (2) tick();

        // Table of single hits; a stray hit mid-stamp must be dropped
        for (int i = 0; i < 9; i++) begin
            start_window();
            if (vecs[i].exp_dots > 0) push_stamp(vecs[i].lx, vecs[i].ly, vecs[i].col, vecs[i].r, 1000);
            drive_hit(vecs[i].lx, vecs[i].ly, vecs[i].col, vecs[i].r);
            a0 = cyc;
            tick();
            laser_valid = 1'b0;
            for (int t = 0; t < 60; t++) begin
                tick();
                if (t == 2 && vecs[i].exp_busy >= 9) drive_hit(40, 40, 1, 0);
                else laser_valid = 1'b0;
            end
            check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].exp_busy);
            check($sformatf("v%0d_dots", i), dot_cnt, vecs[i].exp_dots);
            check($sformatf("v%0d_queue_left", i), exp_q.size(), 0);
            if (vecs[i].exp_busy > 0) begin
                check($sformatf("v%0d_latency", i), first_busy - a0, 2);
                check($sformatf("v%0d_busy_contig", i), last_busy - first_busy + 1, busy_cnt);
            end
        end

        // Clear with a simultaneous hit (clear wins), stray requests mid-sweep
        start_window();
        push_clear();
        clear_req = 1'b1;
        drive_hit(0, 0, 1, 1);
        a0 = cyc;
        tick();
        clear_req = 1'b0; laser_valid = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < NPIX + 100) begin
            tick();
            n++;
            if (n == 100) drive_hit(60, 60, 3, 2);
            else if (n == 200) clear_req = 1'b1;
            else begin laser_valid = 1'b0; clear_req = 1'b0; end
        end
        repeat (10) tick();
        check("clr_latency", first_busy - a0, 2);
        check("clr_busy_cycles", busy_cnt, NPIX);
        check("clr_dots", dot_cnt, NPIX);
        check("clr_done_count", done_cnt, 1);
        check("clr_done_timing", done_cyc, last_busy + 1);
        check("clr_done_busy", int'(done_busy), 0);
        check("clr_queue_left", exp_q.size(), 0);

        // Record is invalidated by the clear: a repeat of the last hit stamps
        start_window();
        push_stamp(201, 101, 2, 1, 1000);
        drive_hit(201, 101, 2, 1);
        tick();
        laser_valid = 1'b0;
        repeat (30) tick();
        check("post_clr_dots", dot_cnt, 9);
        check("post_clr_queue_left", exp_q.size(), 0);

        // r=3 stamp with clear requested in its 10th cycle: no gap before clear
        start_window();
        push_stamp(300, 200, 1, 3, 1000);
        push_clear();
        drive_hit(300, 200, 1, 3);
        a0 = cyc;
        tick();
        laser_valid = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < NPIX + 200) begin
            tick();
            n++;
            clear_req = (cyc == a0 + 11) ? 1'b1 : 1'b0;
        end
        clear_req = 1'b0;
        repeat (5) tick();
        check("pend_busy_cycles", busy_cnt, 49 + NPIX);
        check("pend_no_gap", last_busy - first_busy + 1, busy_cnt);
        check("pend_done_count", done_cnt, 1);
        check("pend_done_timing", done_cyc, last_busy + 1);
        check("pend_queue_left", exp_q.size(), 0);

        // Reset on the 5th cycle of an r=2 stamp aborts it at once
        start_window();
        push_stamp(100, 60, 2, 2, 5);
        drive_hit(100, 60, 2, 2);
        a0 = cyc;
        tick();
        laser_valid = 1'b0;
        while (cyc < a0 + 6) tick();
        reset = 1'b1;
        tick();
        check("abort_drawDot", int'(drawDot), 0);
        check("abort_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (30) tick();
        check("abort_dots", dot_cnt, 5);
        check("abort_queue_left", exp_q.size(), 0);

        start_window();
        push_stamp(100, 60, 2, 2, 1000);
        drive_hit(100, 60, 2, 2);
        tick();
        laser_valid = 1'b0;
        repeat (40) tick();
        check("reissue_busy_cycles", busy_cnt, 25);
        check("reissue_dots", dot_cnt, 25);
        check("reissue_queue_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
